// File: rtl/cla_multiword_adder_seq_if.sv
// Request/result bundle for the sequential multi-word CLA adder.
// The master drives the operands and start; the slave (the adder) returns
// handshake status and the registered result.
interface cla_multiword_adder_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/cla_multiword_adder_seq.sv
// Sequential wide adder: one 16-bit two-level carry-lookahead slice per cycle,
// LSB slice first, with the slice carry-out registered between cycles.
// WIDTH must be a multiple of 16 and at least 16.
module cla_multiword_adder_seq #(
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cla_multiword_adder_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / 16;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [15:0]      sl_a;
  logic [15:0]      sl_b;
  logic [15:0]      sl_s;
  logic             sl_c4;
  logic             sl_c15;

  // 16-bit two-level CLA. Returns {carry out of bit 15, carry into bit 15, sum}.
  // Group carries come straight from group P/G and the slice carry-in, so no
  // carry ripples from one 4-bit group to the next.
  function automatic logic [17:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        c0);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] bc;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;
    int          b;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < 4; j++) begin
      b     = 4 * j;
      gp[j] = p[b+3] & p[b+2] & p[b+1] & p[b];
      gg[j] = g[b+3]
            | (p[b+3] & g[b+2])
            | (p[b+3] & p[b+2] & g[b+1])
            | (p[b+3] & p[b+2] & p[b+1] & g[b]);
    end
    gc[0] = c0;
    gc[1] = gg[0] | (gp[0] & c0);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c0);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
    for (int j = 0; j < 4; j++) begin
      b       = 4 * j;
      bc[b]   = gc[j];
      bc[b+1] = g[b] | (p[b] & gc[j]);
      bc[b+2] = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & gc[j]);
      bc[b+3] = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b])
              | (p[b+2] & p[b+1] & p[b] & gc[j]);
    end
    return {gc[4], bc[15], p ^ bc};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for NSLICE edges, DONE for one.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state; ready is high during reset since state is IDLE.
  always_comb begin
    bus.ready = (state == S_IDLE);
    bus.busy  = (state == S_RUN);
    bus.done  = (state == S_DONE);
  end

  // Select the current slice of the captured operands.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx == IDXW'(k)) begin
        sl_a = a_q[16*k +: 16];
        sl_b = b_q[16*k +: 16];
      end
    end
  end

  assign {sl_c4, sl_c15, sl_s} = cla16(sl_a, sl_b, carry_q);

  // Operand capture, per-slice sum write-back and final carry/overflow.
  // Everything clears on reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx     <= '0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (idx == IDXW'(k)) sum_q[16*k +: 16] <= sl_s;
          end
          carry_q <= sl_c4;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_q <= sl_c4;
            ovf_q  <= sl_c15 ^ sl_c4;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_cla_multiword_adder_seq.sv
// Bench for cla_multiword_adder_seq: WIDTH=16/32/64 instances side by side,
// a vector table on the 64-bit build, hand sequences for mid-run start/reset,
// and back-to-back random operations on the 16/32-bit builds. Expected
// results go into a per-instance scoreboard queue and are checked on done.
module tb_cla_multiword_adder_seq;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          scyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  logic [2:0]       start_d;
  logic [2:0][63:0] a_d;
  logic [2:0][63:0] b_d;
  logic [2:0]       cin_d;
  logic [2:0]       rdy, bsy, dn, co, ov;
  logic [2:0][63:0] sum_o;

  exp_t sb [3][$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   bb_mode = 0;
  int   last_done [3];
  bit   prev_dn [3];
  exp_t mon_e;
  vec_t tbl [9];

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int W = 16 << gi;
    cla_multiword_adder_seq_if #(.WIDTH(W)) bus ();
    assign bus.start  = start_d[gi];
    assign bus.a      = a_d[gi][W-1:0];
    assign bus.b      = b_d[gi][W-1:0];
    assign bus.cin    = cin_d[gi];
    assign rdy[gi]    = bus.ready;
    assign bsy[gi]    = bus.busy;
    assign dn[gi]     = bus.done;
    assign co[gi]     = bus.cout;
    assign ov[gi]     = bus.overflow;
    assign sum_o[gi]  = 64'(bus.sum);
    cla_multiword_adder_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input int d, input logic [63:0] act,
                     input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, d, act, expv);
    end
  endtask

  // Reference: plain wide addition; overflow from operand/result sign bits.
  function automatic exp_t model(input int d, input logic [63:0] a,
                                 input logic [63:0] b, input logic cin);
    exp_t        e;
    int          w;
    logic [63:0] m;
    logic [64:0] t;
    w = 16 << d;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    t = {1'b0, a & m} + {1'b0, b & m} + {64'd0, cin};
    e.sum  = t[63:0] & m;
    e.cout = t[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    e.scyc = 0;
    return e;
  endfunction

  task automatic wait_ready(input int d, output bit ok);
    @(negedge clk);
    for (int t = 0; t < 50 && !rdy[d]; t++) @(negedge clk);
    ok = rdy[d];
    if (!ok) chk("ready_timeout", d, {63'd0, rdy[d]}, 64'd1);
  endtask

  task automatic do_op(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic [63:0] es, input logic ec,
                       input logic eo);
    bit   ok;
    exp_t e;
    wait_ready(d, ok);
    if (!ok) return;
    start_d[d] = 1'b1;
    a_d[d]     = a;
    b_d[d]     = b;
    cin_d[d]   = cin;
    e.sum = es; e.cout = ec; e.ovf = eo; e.scyc = cyc + 1;
    sb[d].push_back(e);
    @(posedge clk);
    #1 start_d[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    for (int t = 0; t < 200 && sb[d].size() != 0; t++) @(negedge clk);
    if (sb[d].size() != 0) chk("drain_timeout", d, 64'(sb[d].size()), 64'd0);
    @(negedge clk);
  endtask

  // Hold start high and feed fresh random operands whenever the instance is ready.
  task automatic bb_run(input int d, input int nops);
    int   nacc;
    exp_t e;
    nacc = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (rdy[d]) begin
        if (nacc < nops) begin
          a_d[d]     = {$urandom, $urandom};
          b_d[d]     = {$urandom, $urandom};
          cin_d[d]   = 1'($urandom_range(0, 1));
          start_d[d] = 1'b1;
          e = model(d, a_d[d], b_d[d], cin_d[d]);
          e.scyc = cyc + 1;
          sb[d].push_back(e);
          nacc++;
        end else begin
          start_d[d] = 1'b0;
          break;
        end
      end
    end
    start_d[d] = 1'b0;
    if (nacc != nops) chk("bb_accept_count", d, 64'(nacc), 64'(nops));
  endtask

  initial begin
    bit ok;
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[3] = '{64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    tbl[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0};
    tbl[5] = '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0};
    tbl[6] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[8] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    start_d = '0;
    a_d     = '0;
    b_d     = '0;
    cin_d   = '0;
    for (int i = 0; i < 3; i++) begin
      last_done[i] = -1;
      prev_dn[i]   = 1'b0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (prev_dn[i]) chk("done_width", i, {63'd0, dn[i]}, 64'd0);
          if (dn[i]) begin
            if (sb[i].size() == 0) begin
              chk("unexpected_done", i, 64'd1, 64'd0);
            end else begin
              mon_e = sb[i].pop_front();
              chk("sum", i, sum_o[i], mon_e.sum);
              chk("cout", i, {63'd0, co[i]}, {63'd0, mon_e.cout});
              chk("overflow", i, {63'd0, ov[i]}, {63'd0, mon_e.ovf});
              chk("latency", i, 64'(cyc - mon_e.scyc), 64'(1 << i));
              if (bb_mode && last_done[i] >= 0)
                chk("done_period", i, 64'(cyc - last_done[i]), 64'((1 << i) + 2));
              last_done[i] = bb_mode ? cyc : -1;
            end
          end
          prev_dn[i] = dn[i];
        end
      end
    join_none

    // Reset state on every build.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, {63'd0, rdy[i]}, 64'd1);
      chk("rst_busy", i, {63'd0, bsy[i]}, 64'd0);
      chk("rst_done", i, {63'd0, dn[i]}, 64'd0);
      chk("rst_sum", i, sum_o[i], 64'd0);
      chk("rst_cout", i, {63'd0, co[i]}, 64'd0);
      chk("rst_ovf", i, {63'd0, ov[i]}, 64'd0);
    end
    rst_n = 1'b1;

    // Vector table on the 64-bit build.
    for (int v = 0; v < 9; v++) begin
      do_op(2, tbl[v].a, tbl[v].b, tbl[v].cin, tbl[v].sum, tbl[v].cout, tbl[v].ovf);
      wait_drain(2);
    end

    // Start re-pulsed and operands changed mid-run: first capture wins.
    wait_ready(2, ok);
    if (ok) begin
      start_d[2] = 1'b1;
      a_d[2] = 64'h1234_5678_9ABC_DEF0;
      b_d[2] = 64'h0FED_CBA9_8765_4321;
      cin_d[2] = 1'b0;
      mon_e.sum = 64'h2222_2222_2222_2211; mon_e.cout = 1'b0; mon_e.ovf = 1'b0;
      mon_e.scyc = cyc + 1;
      sb[2].push_back(mon_e);
      @(posedge clk);
      #1;
      a_d[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      b_d[2] = 64'h1111_1111_1111_1111;
      cin_d[2] = 1'b1;
      chk("run_busy", 2, {63'd0, bsy[2]}, 64'd1);
      chk("run_ready", 2, {63'd0, rdy[2]}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 start_d[2] = 1'b0;
      wait_drain(2);
    end

    // Reset after two RUN edges: partial result must vanish at once.
    wait_ready(2, ok);
    if (ok) begin
      start_d[2] = 1'b1;
      a_d[2] = 64'h1234_5678_9ABC_DEF0;
      b_d[2] = 64'h0FED_CBA9_8765_4321;
      cin_d[2] = 1'b0;
      @(posedge clk);
      #1 start_d[2] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_sum", 2, sum_o[2], 64'd0);
      chk("abort_ready", 2, {63'd0, rdy[2]}, 64'd1);
      chk("abort_busy", 2, {63'd0, bsy[2]}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(2, 64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0);
      wait_drain(2);
    end

    // Back-to-back random traffic on the 16- and 32-bit builds.
    bb_mode = 1'b1;
    fork
      bb_run(0, 10);
      bb_run(1, 10);
    join
    wait_drain(0);
    wait_drain(1);
    bb_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
